// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection traffic-light controller:
// lamp encoding, controller states and per-state phase durations.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10,
        OFF    = 2'b11
    } color_t;

    typedef enum logic [2:0] {
        ST_ALL_RED,
        ST_GREEN,
        ST_YELLOW,
        ST_WALK,
        ST_FLASH
    } state_t;

    // Cycles spent in a state; in FLASH this is the blink half-period.
    function automatic int unsigned phase_dur(
        input state_t      s,
        input int unsigned green_cyc,
        input int unsigned yellow_cyc,
        input int unsigned allred_cyc,
        input int unsigned walk_cyc,
        input int unsigned flash_half
    );
        case (s)
            ST_GREEN:  return green_cyc;
            ST_YELLOW: return yellow_cyc;
            ST_WALK:   return walk_cyc;
            ST_FLASH:  return flash_half;
            default:   return allred_cyc;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter that parks at zero; done flags the final cycle
// of the interval being timed.
module phase_timer #(
    parameter int             CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/traffic_ctrl.sv
// Round-robin intersection controller with latched pedestrian walk phase
// and maintenance flash mode; all lamp/walk outputs are registered.
module traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_WAYS   = 2,
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 10,
    parameter int FLASH_HALF = 5,
    parameter int CNT_W      = 8,
    localparam int AW        = (NUM_WAYS > 2) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flash_en,
    input  logic [NUM_WAYS-1:0]   ped_req,
    output logic [2*NUM_WAYS-1:0] color,
    output logic [NUM_WAYS-1:0]   walk,
    output logic [AW-1:0]         active_way
);

    state_t                state, state_next;
    logic [AW-1:0]         way, way_next;
    logic [NUM_WAYS-1:0]   ped_pend, ped_pend_next, walk_next;
    logic [2*NUM_WAYS-1:0] color_next;
    logic                  blink_off, blink_off_next;
    logic                  phase_load, phase_done;
    logic                  blink_load, blink_done;
    logic [CNT_W-1:0]      phase_load_val, blink_load_val;
    logic                  walk_entry;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(ALLRED_CYC - 1))
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (phase_load),
        .load_val (phase_load_val),
        .done     (phase_done)
    );

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(FLASH_HALF - 1))
    ) u_blink_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (blink_load),
        .load_val (blink_load_val),
        .done     (blink_done)
    );

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_next = state;
        way_next   = way;

        if (flash_en && state != ST_FLASH) begin
            state_next = ST_FLASH;
        end else begin
            case (state)
                ST_ALL_RED: if (phase_done) state_next = ST_GREEN;
                ST_GREEN:   if (phase_done) state_next = ST_YELLOW;
                ST_YELLOW: begin
                    if (phase_done) begin
                        way_next   = (way == AW'(NUM_WAYS - 1)) ? '0 : way + AW'(1);
                        state_next = (|ped_pend) ? ST_WALK : ST_ALL_RED;
                    end
                end
                ST_WALK:    if (phase_done) state_next = ST_ALL_RED;
                ST_FLASH: begin
                    if (!flash_en) begin
                        state_next = ST_ALL_RED;
                        way_next   = '0;
                    end
                end
                default:    state_next = ST_ALL_RED;
            endcase
        end

        phase_load     = (state_next != state);
        phase_load_val = CNT_W'(phase_dur(state_next, GREEN_CYC, YELLOW_CYC,
                                          ALLRED_CYC, WALK_CYC, FLASH_HALF) - 1);

        // Blink always restarts on yellow when flash mode is entered.
        blink_load     = (state_next == ST_FLASH) && (state != ST_FLASH || blink_done);
        blink_load_val = CNT_W'(FLASH_HALF - 1);
        blink_off_next = 1'b0;
        if (state_next == ST_FLASH && state == ST_FLASH) begin
            blink_off_next = blink_done ? ~blink_off : blink_off;
        end

        // A request coinciding with walk entry survives into the next walk phase.
        walk_entry    = (state_next == ST_WALK) && (state != ST_WALK);
        ped_pend_next = (walk_entry ? '0 : ped_pend) | ped_req;
        walk_next     = '0;
        if (state_next == ST_WALK) begin
            walk_next = walk_entry ? ped_pend : walk;
        end

        color_next = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            case (state_next)
                ST_GREEN:  color_next[2*i +: 2] = (way_next == AW'(i)) ? GREEN  : RED;
                ST_YELLOW: color_next[2*i +: 2] = (way_next == AW'(i)) ? YELLOW : RED;
                ST_FLASH:  color_next[2*i +: 2] = blink_off_next ? OFF : YELLOW;
                default:   color_next[2*i +: 2] = RED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_ALL_RED;
            way       <= '0;
            ped_pend  <= '0;
            blink_off <= 1'b0;
            color     <= '0;
            walk      <= '0;
        end else begin
            state     <= state_next;
            way       <= way_next;
            ped_pend  <= ped_pend_next;
            blink_off <= blink_off_next;
            color     <= color_next;
            walk      <= walk_next;
        end
    end

    assign active_way = way;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed bench for traffic_ctrl: free run, pedestrian walks, flash mode,
// mid-operation reset, plus a three-way instance checked for order and period.
module tb_traffic_ctrl;

    logic       clk;
    logic       reset;
    logic       flash_en;
    logic [1:0] ped_req;
    logic [3:0] color;
    logic [1:0] walk;
    logic [0:0] active_way;

    logic [2:0] ped_req3;
    logic [5:0] color3;
    logic [2:0] walk3;
    logic [1:0] active_way3;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    traffic_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .flash_en   (flash_en),
        .ped_req    (ped_req),
        .color      (color),
        .walk       (walk),
        .active_way (active_way)
    );

    traffic_ctrl #(.NUM_WAYS(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .flash_en   (1'b0),
        .ped_req    (ped_req3),
        .color      (color3),
        .walk       (walk3),
        .active_way (active_way3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle c is observed at the falling edge at time 10*c; inputs set there
    // are sampled by the rising edge that ends cycle c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        flash_en = 1'b0;
        ped_req  = '0;
        ped_req3 = '0;

        goto(2);
        chk("rst_color", color, 4'b0000);
        chk("rst_walk",  walk, 2'b00);
        chk("rst_way",   active_way, 1'b0);
        chk("rst_pend",  dut.ped_pend, 2'b00);
        reset = 1'b0;

        // Free run
        goto(3);   chk("fr_c3_red",      color, 4'b0000);
        goto(4);   chk("fr_c4_g0",       color, 4'b0010);
        chk("fr_c4_way", active_way, 1'b0);
        goto(23);  chk("fr_c23_g0",      color, 4'b0010);
        goto(24);  chk("fr_c24_y0",      color, 4'b0001);
        goto(27);  chk("fr_c27_y0",      color, 4'b0001);
        goto(28);  chk("fr_c28_red",     color, 4'b0000);
        chk("fr_c28_way", active_way, 1'b1);
        goto(29);  chk("fr_c29_red",     color, 4'b0000);
        goto(30);  chk("fr_c30_g1",      color, 4'b1000);
        chk("w3_c30_g1", color3, 6'b001000);
        goto(49);  chk("fr_c49_g1",      color, 4'b1000);
        goto(50);  chk("fr_c50_y1",      color, 4'b0100);
        goto(53);  chk("fr_c53_y1",      color, 4'b0100);
        goto(56);  chk("fr_c56_g0",      color, 4'b0010);
        chk("fr_c56_way", active_way, 1'b0);
        chk("w3_c56_g2",  color3, 6'b100000);
        chk("w3_c56_way", active_way3, 2'd2);
        goto(81);  chk("w3_c81_red",     color3, 6'b000000);
        chk("w3_c81_walk", walk3, 3'b000);
        goto(82);  chk("w3_c82_g0",      color3, 6'b000010);
        chk("w3_c82_way", active_way3, 2'd0);
        goto(108); chk("fr_c108_g0",     color, 4'b0010);

        // Pedestrian request during way0 green
        goto(110); ped_req = 2'b10;
        goto(111); ped_req = 2'b00;
        chk("ped_latch", dut.ped_pend, 2'b10);
        goto(131); chk("ped_y0_end",     color, 4'b0001);
        chk("ped_nowalk_y", walk, 2'b00);
        goto(132); chk("walk_color",     color, 4'b0000);
        chk("walk_grant", walk, 2'b10);
        chk("walk_cleared", dut.ped_pend, 2'b00);
        chk("walk_way", active_way, 1'b1);

        // Request during walk is deferred
        goto(135); ped_req = 2'b01;
        goto(136); ped_req = 2'b00;
        chk("walk_req_pend", dut.ped_pend, 2'b01);
        chk("walk_req_notnow", walk, 2'b10);
        goto(141); chk("walk_last",      walk, 2'b10);
        goto(142); chk("walk_off",       walk, 2'b00);
        chk("post_walk_red", color, 4'b0000);
        goto(143); chk("post_walk_red2", color, 4'b0000);
        goto(144); chk("post_walk_g1",   color, 4'b1000);
        goto(167); chk("y1_end",         color, 4'b0100);
        goto(168); chk("walk2_grant",    walk, 2'b01);
        chk("walk2_color", color, 4'b0000);
        chk("walk2_way", active_way, 1'b0);
        goto(178); chk("walk2_off",      walk, 2'b00);
        goto(180); chk("walk2_g0",       color, 4'b0010);

        // Flash mode from mid-green
        goto(185); flash_en = 1'b1;
        goto(186); chk("fl_y_first",     color, 4'b0101);
        chk("fl_walk", walk, 2'b00);
        goto(188); ped_req = 2'b10;
        goto(189); ped_req = 2'b00;
        goto(190); chk("fl_y_last",      color, 4'b0101);
        chk("fl_pend", dut.ped_pend, 2'b10);
        goto(191); chk("fl_off_first",   color, 4'b1111);
        goto(195); chk("fl_off_last",    color, 4'b1111);
        goto(196); chk("fl_y_again",     color, 4'b0101);
        goto(198); flash_en = 1'b0;
        goto(199); chk("fl_exit_red",    color, 4'b0000);
        chk("fl_exit_way", active_way, 1'b0);
        goto(200); chk("fl_exit_red2",   color, 4'b0000);
        goto(201); chk("fl_exit_g0",     color, 4'b0010);
        goto(224); chk("fl_y0_end",      color, 4'b0001);
        goto(225); chk("fl_walk_grant",  walk, 2'b10);
        goto(237); chk("fl_g1",          color, 4'b1000);

        // Reset during way1 yellow with a request pending
        goto(240); ped_req = 2'b01;
        goto(241); ped_req = 2'b00;
        goto(257); chk("rs_y1",          color, 4'b0100);
        chk("rs_pend_before", dut.ped_pend, 2'b01);
        goto(258); reset = 1'b1;
        goto(259); reset = 1'b0;
        chk("rs_color", color, 4'b0000);
        chk("rs_walk",  walk, 2'b00);
        chk("rs_pend",  dut.ped_pend, 2'b00);
        chk("rs_way",   active_way, 1'b0);
        goto(260); chk("rs_red2",        color, 4'b0000);
        goto(261); chk("rs_g0_first",    color, 4'b0010);
        goto(280); chk("rs_g0_last",     color, 4'b0010);
        goto(281); chk("rs_y0",          color, 4'b0001);
        goto(285); chk("rs_red",         color, 4'b0000);
        chk("rs_way1", active_way, 1'b1);
        goto(287); chk("rs_g1",          color, 4'b1000);
        chk("rs_walk_none", walk, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
